pea_fire_scheduler: RTL and testbench

Firing scheduler for the PEA actor. Sits between the PEA enable module and the PEA invoke module: it samples `enable`, raises `invoke`, holds it until `FC`, and then advances the CFDF mode (SETUP_INSTR → INSTR → OUTPUT) driven into both modules. It replaces hand-sequenced testbench invokes with a self-running loop and adds a firing counter and a watchdog for hung firings.

---
 rtl/pea_fire_scheduler_if.sv | 28 ++
 rtl/pea_fire_scheduler.sv | 108 ++++++++++
 tb/tb_pea_fire_scheduler.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/pea_fire_scheduler_if.sv
// Scheduler <-> PEA enable/invoke signal bundle. The slave modport is the scheduler side.
// Handshake: invoke stays high until FC is sampled high; FC/has_output are then held by the invoke module until it drops FC.
interface pea_fire_scheduler_if #(
    parameter int CNT_W = 16
);
    logic             run;
    logic             enable;
    logic             FC;
    logic             has_output;
    logic             clr_err;
    logic             invoke;
    logic [1:0]       next_instr;
    logic             busy;
    logic             timeout_err;
    logic [CNT_W-1:0] fire_count;
    logic [CNT_W-1:0] stall_count;
    logic [2:0]       fsm_state;

    modport slave (
        input  run, enable, FC, has_output, clr_err,
        output invoke, next_instr, busy, timeout_err, fire_count, stall_count, fsm_state
    );

    modport master (
        output run, enable, FC, has_output, clr_err,
        input  invoke, next_instr, busy, timeout_err, fire_count, stall_count, fsm_state
    );
endinterface

// File: rtl/pea_fire_scheduler.sv
// Self-running CFDF firing loop for the PEA actor: invoke, wait for FC, advance mode.
// PEA_SCHED_STALL_CNT_EN enables the saturating stall counter; otherwise stall_count is tied to 0.
module pea_fire_scheduler #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 16
) (
    input logic                 clk,
    input logic                 rst,
    pea_fire_scheduler_if.slave bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CHECK   = 3'd1;
    localparam logic [2:0] S_FIRE    = 3'd2;
    localparam logic [2:0] S_WAIT_FC = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;
    localparam logic [2:0] S_ERR     = 3'd5;

    localparam logic [1:0] M_SETUP  = 2'b00;
    localparam logic [1:0] M_INSTR  = 2'b01;
    localparam logic [1:0] M_OUTPUT = 2'b10;

    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]       state, state_nx;
    logic             invoke_q;
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] fire_cnt;
    logic [WD_W-1:0]  wd;
    logic             has_out_q;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (bus.run) state_nx = S_CHECK;
            S_CHECK: begin
                if (!bus.run)        state_nx = S_IDLE;
                else if (bus.enable) state_nx = S_FIRE;
            end
            S_FIRE:    state_nx = S_WAIT_FC;
            // FC wins over the watchdog on the last allowed cycle.
            S_WAIT_FC: begin
                if (bus.FC)            state_nx = S_RELEASE;
                else if (wd == WD_LAST) state_nx = S_ERR;
            end
            S_RELEASE: if (!bus.FC) state_nx = S_CHECK;
            S_ERR:     if (bus.clr_err) state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            invoke_q  <= 1'b0;
            mode_q    <= M_SETUP;
            fire_cnt  <= '0;
            wd        <= '0;
            has_out_q <= 1'b0;
        end else begin
            state    <= state_nx;
            invoke_q <= (state_nx == S_FIRE) || (state_nx == S_WAIT_FC);
            case (state)
                S_FIRE: wd <= '0;
                S_WAIT_FC: begin
                    if (bus.FC)             has_out_q <= bus.has_output;
                    else if (wd != WD_LAST) wd <= wd + 1'b1;
                end
                // Mode only moves here and on ERR exit, so it is stable throughout CHECK.
                S_RELEASE: begin
                    if (!bus.FC) begin
                        fire_cnt <= fire_cnt + 1'b1;
                        case (mode_q)
                            M_SETUP: mode_q <= M_INSTR;
                            M_INSTR: mode_q <= has_out_q ? M_OUTPUT : M_SETUP;
                            default: mode_q <= M_SETUP;
                        endcase
                    end
                end
                S_ERR: if (bus.clr_err) mode_q <= M_SETUP;
                default: ;
            endcase
        end
    end

`ifdef PEA_SCHED_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (state == S_CHECK && bus.run && !bus.enable && stall_cnt != {CNT_W{1'b1}}) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign bus.stall_count = stall_cnt;
`else
    assign bus.stall_count = '0;
`endif

    assign bus.invoke      = invoke_q;
    assign bus.next_instr  = mode_q;
    assign bus.busy        = (state != S_IDLE) && (state != S_ERR);
    assign bus.timeout_err = (state == S_ERR);
    assign bus.fire_count  = fire_cnt;
    assign bus.fsm_state   = state;
endmodule

// File: tb/tb_pea_fire_scheduler.sv
// Directed bench for pea_fire_scheduler: table-driven firing loop plus hand-written corner sequences.
module tb_pea_fire_scheduler;
    localparam int CNT_W = 16;
    localparam int TO    = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pea_fire_scheduler_if #(.CNT_W(CNT_W)) bus ();

    pea_fire_scheduler #(.TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             run;
        logic             enable;
        logic             fc;
        logic             has_output;
        logic             exp_invoke;
        logic [1:0]       exp_mode;
        logic             exp_busy;
        logic [CNT_W-1:0] exp_fire;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic e, logic f, logic h, logic inv,
                                logic [1:0] m, logic b, int fc_cnt);
        vec_t v;
        v.run = r; v.enable = e; v.fc = f; v.has_output = h;
        v.exp_invoke = inv; v.exp_mode = m; v.exp_busy = b; v.exp_fire = CNT_W'(fc_cnt);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic e, input logic f, input logic h, input logic c);
        bus.run = r; bus.enable = e; bus.FC = f; bus.has_output = h; bus.clr_err = c;
    endtask

    task automatic check_outputs(input string tag, input logic inv, input logic [1:0] m,
                                 input logic b, input logic te, input int fc_cnt);
        check({tag, ".invoke"},      32'(bus.invoke),      32'(inv));
        check({tag, ".next_instr"},  32'(bus.next_instr),  32'(m));
        check({tag, ".busy"},        32'(bus.busy),        32'(b));
        check({tag, ".timeout_err"}, 32'(bus.timeout_err), 32'(te));
        check({tag, ".fire_count"},  32'(bus.fire_count),  32'(fc_cnt));
    endtask

    initial begin
        int exp_stall;
        checks = 0;
        errors = 0;
        rst = 1'b0;
        drive(0, 0, 0, 0, 0);

        // Three firings with output, INSTR firing without output, 5-cycle stall.
        vecs.push_back(mk(1,1,0,0, 0,2'd0,1,0));
        vecs.push_back(mk(1,1,0,0, 1,2'd0,1,0));
        vecs.push_back(mk(1,1,0,0, 1,2'd0,1,0));
        vecs.push_back(mk(1,1,0,0, 1,2'd0,1,0));
        vecs.push_back(mk(1,1,0,0, 1,2'd0,1,0));
        vecs.push_back(mk(1,1,1,1, 0,2'd0,1,0));
        vecs.push_back(mk(1,1,0,0, 0,2'd1,1,1));
        vecs.push_back(mk(1,1,0,0, 1,2'd1,1,1));
        vecs.push_back(mk(1,1,0,0, 1,2'd1,1,1));
        vecs.push_back(mk(1,1,0,0, 1,2'd1,1,1));
        vecs.push_back(mk(1,1,1,1, 0,2'd1,1,1));
        vecs.push_back(mk(1,1,0,0, 0,2'd2,1,2));
        vecs.push_back(mk(1,1,0,0, 1,2'd2,1,2));
        vecs.push_back(mk(1,1,0,0, 1,2'd2,1,2));
        vecs.push_back(mk(1,1,1,0, 0,2'd2,1,2));
        vecs.push_back(mk(1,1,0,0, 0,2'd0,1,3));
        vecs.push_back(mk(1,1,0,0, 1,2'd0,1,3));
        vecs.push_back(mk(1,1,0,0, 1,2'd0,1,3));
        vecs.push_back(mk(1,1,1,1, 0,2'd0,1,3));
        vecs.push_back(mk(1,1,0,0, 0,2'd1,1,4));
        vecs.push_back(mk(1,1,0,0, 1,2'd1,1,4));
        vecs.push_back(mk(1,1,0,0, 1,2'd1,1,4));
        vecs.push_back(mk(1,1,1,0, 0,2'd1,1,4));
        vecs.push_back(mk(1,1,0,0, 0,2'd0,1,5));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(1,0,0,0, 0,2'd0,1,5));
        vecs.push_back(mk(1,1,0,0, 1,2'd0,1,5));
        vecs.push_back(mk(1,1,0,0, 1,2'd0,1,5));
        vecs.push_back(mk(1,1,1,0, 0,2'd0,1,5));
        vecs.push_back(mk(1,1,0,0, 0,2'd1,1,6));
        vecs.push_back(mk(0,1,0,0, 0,2'd1,0,6));

        // Reset state
        #12;
        check_outputs("reset", 0, 2'd0, 0, 0, 0);
        check("reset.stall_count", 32'(bus.stall_count), 32'd0);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].run, vecs[i].enable, vecs[i].fc, vecs[i].has_output, 0);
            tick();
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_invoke, vecs[i].exp_mode,
                          vecs[i].exp_busy, 0, 32'(vecs[i].exp_fire));
        end

`ifdef PEA_SCHED_STALL_CNT_EN
        exp_stall = 5;
`else
        exp_stall = 0;
`endif
        check("stall_count", 32'(bus.stall_count), 32'(exp_stall));

        // Watchdog: FC never arrives.
        drive(1, 1, 0, 0, 0);
        tick();
        tick();
        check("wd.invoke_rise", 32'(bus.invoke), 32'd1);
        for (int i = 0; i < TO; i++) tick();
        check("wd.no_err_yet", 32'(bus.timeout_err), 32'd0);
        tick();
        check_outputs("wd.err", 0, 2'd1, 0, 1, 6);
        tick();
        tick();
        check("wd.err_sticky", 32'(bus.timeout_err), 32'd1);
        drive(0, 1, 0, 0, 1);
        tick();
        drive(0, 1, 0, 0, 0);
        check_outputs("wd.clr", 0, 2'd0, 0, 0, 6);
        check("wd.clr_state", 32'(bus.fsm_state), 32'd0);

        // FC on the last allowed WAIT_FC cycle wins.
        drive(1, 1, 0, 0, 0);
        tick();
        tick();
        for (int i = 0; i < TO; i++) tick();
        check("late_fc.invoke_held", 32'(bus.invoke), 32'd1);
        drive(1, 1, 1, 0, 0);
        tick();
        check_outputs("late_fc.release", 0, 2'd0, 1, 0, 6);
        drive(1, 1, 0, 0, 0);
        tick();
        check_outputs("late_fc.done", 0, 2'd1, 1, 0, 7);

        // Sticky FC with run dropped mid-firing.
        tick();
        check("sticky.fire", 32'(bus.invoke), 32'd1);
        tick();
        drive(0, 1, 0, 0, 0);
        tick();
        check("sticky.run_ignored", 32'(bus.invoke), 32'd1);
        drive(0, 1, 1, 1, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_outputs($sformatf("sticky.fc%0d", i), 0, 2'd1, 1, 0, 7);
        end
        drive(0, 1, 0, 0, 0);
        tick();
        check_outputs("sticky.release", 0, 2'd2, 1, 0, 8);
        tick();
        check_outputs("sticky.idle", 0, 2'd2, 0, 0, 8);
        for (int i = 0; i < 3; i++) tick();
        check_outputs("sticky.no_reinvoke", 0, 2'd2, 0, 0, 8);

        // Asynchronous reset mid WAIT_FC.
        drive(1, 1, 0, 0, 0);
        tick();
        tick();
        tick();
        check("areset.pre_invoke", 32'(bus.invoke), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_outputs("areset", 0, 2'd0, 0, 0, 0);
        check("areset.stall_count", 32'(bus.stall_count), 32'd0);
        #3;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        tick();
        check_outputs("areset.after", 0, 2'd0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
